// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: data widths and the fetch-queue entry layout.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    // One fetched instruction together with its fall-through address.
    typedef struct packed {
        logic [PC_W-1:0]    pc_plus4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry fetch-entry FIFO with registered head/tail pointers and a
// single-cycle flush; the head entry reads combinationally (zero when empty).
module fq_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head_entry,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    fetch_entry_t     mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)  head_reg <= head_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; empty slots are masked on the read side.
    always_ff @(posedge clk_i) begin
        if (rst_n && !flush && push) begin
            mem[tail_reg] <= wr_entry;
        end
    end

    assign head_entry = (count_reg == '0) ? '0 : mem[head_reg];
    assign count      = count_reg;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch PC plus decoupling queue toward decode.
// Optional macro FETCH_QUEUE_BYPASS_EN lets an empty queue forward imem data straight to decode.
module instr_fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk_i,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    output logic               id_valid_o,
    output logic [INSTR_W-1:0] id_instr_o,
    output logic [PC_W-1:0]    id_pc_plus4_o,
    input  logic               id_ready_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_plus4;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     head_entry;
    fetch_entry_t     wr_entry;
    logic             queue_empty;
    logic             queue_full;
    logic             bypass_active;
    logic             bypass_take;
    logic             pop;
    logic             push;
    logic             fifo_push;
    logic             fifo_pop;

    assign pc_plus4    = pc_q + 32'd4;
    assign imem_addr_o = pc_q;
    assign queue_empty = (fifo_count == '0);
    assign queue_full  = (fifo_count == CNT_W'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_active = queue_empty & ~redirect_i;
`else
    assign bypass_active = 1'b0;
`endif

    always_comb begin
        id_valid_o    = ~queue_empty | bypass_active;
        id_instr_o    = head_entry.instr;
        id_pc_plus4_o = head_entry.pc_plus4;
        if (bypass_active) begin
            id_instr_o    = imem_instr_i;
            id_pc_plus4_o = pc_plus4;
        end
    end

    assign pop  = id_valid_o & id_ready_i;
    assign push = ~redirect_i & (~queue_full | pop);

    // A bypassed instruction consumed by decode never occupies a slot.
    assign bypass_take = bypass_active & id_ready_i;
    assign fifo_push   = push & ~bypass_take;
    assign fifo_pop    = pop & ~queue_empty;

    assign wr_entry.pc_plus4 = pc_plus4;
    assign wr_entry.instr    = imem_instr_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (redirect_i) begin
            pc_q <= {redirect_pc_i[PC_W-1:2], 2'b00};
        end else if (push) begin
            pc_q <= pc_plus4;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .flush      (redirect_i),
        .push       (fifo_push),
        .pop        (fifo_pop),
        .wr_entry   (wr_entry),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: queue-based reference model compared
// every cycle, plus hand-computed checkpoints. Honors FETCH_QUEUE_BYPASS_EN.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        id_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_plus4_o;

    bit          ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;

    int tests  = 0;
    int failed = 0;

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .imem_addr_o   (imem_addr_o),
        .imem_instr_i  (imem_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_plus4_o (id_pc_plus4_o),
        .id_ready_i    (id_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Instruction memory: content derived from the address unless overridden.
    always_comb imem_instr_i = ovr_en ? ovr_val : (imem_addr_o ^ 32'h1357_9BDF);

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ovr_en ? ovr_val : (a ^ 32'h1357_9BDF);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_ok = 1'b0;

    task automatic model_step();
        bit vld;
        bit pop;
        if (!rst_n) begin
            m_pc = RESET_PC;
            q.delete();
            m_ok = 1'b1;
        end else if (m_ok) begin
            vld = (q.size() != 0) || (BYPASS && !redirect_i);
            pop = vld && id_ready_i;
            if (redirect_i) begin
                q.delete();
                m_pc = {redirect_pc_i[31:2], 2'b00};
            end else if (q.size() == 0 && BYPASS && id_ready_i) begin
                m_pc = m_pc + 32'd4;
            end else begin
                if (pop) void'(q.pop_front());
                if (q.size() < DEPTH) begin
                    q.push_back('{m_pc + 32'd4, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        model_step();
    end

    // Per-cycle comparison on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk_i);
        if (m_ok) begin
            logic        e_valid;
            logic [31:0] e_instr;
            logic [31:0] e_pc4;
            e_valid = (q.size() != 0) || (BYPASS && !redirect_i);
            e_instr = 32'h0;
            e_pc4   = 32'h0;
            if (q.size() != 0) begin
                e_instr = q[0].instr;
                e_pc4   = q[0].pc4;
            end else if (e_valid) begin
                e_instr = mem_word(m_pc);
                e_pc4   = m_pc + 32'd4;
            end
            check("m_imem_addr", imem_addr_o, m_pc);
            check("m_id_valid", {31'd0, id_valid_o}, {31'd0, e_valid});
            check("m_id_instr", id_instr_o, e_instr);
            check("m_id_pc4", id_pc_plus4_o, e_pc4);
            check("m_count", 32'(u_dut.fifo_count), 32'(q.size()));
        end
    end

    task automatic step(input bit r, input bit redir, input logic [31:0] rpc, input bit rdy);
        rst_n         = r;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        id_ready_i    = rdy;
        @(posedge clk_i);
        #1;
        $display("[TB] t=%0t rst_n=%b redir=%b rdy=%b addr=%h valid=%b instr=%h pc4=%h",
                 $time, r, redir, rdy, imem_addr_o, id_valid_o, id_instr_o, id_pc_plus4_o);
    endtask

    logic [47:0] rdy_pat;

    initial begin
        // Reset held two cycles.
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("rst_addr", imem_addr_o, RESET_PC);

`ifndef FETCH_QUEUE_BYPASS_EN
        check("rst_valid", {31'd0, id_valid_o}, 32'd0);
        check("rst_pc4", id_pc_plus4_o, 32'd0);
        check("rst_instr", id_instr_o, 32'd0);

        // Streaming after release.
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            check("stream_addr", imem_addr_o, 32'(4 * k));
            check("stream_valid", {31'd0, id_valid_o}, 32'd1);
            check("stream_pc4", id_pc_plus4_o, 32'(4 * k));
        end

        // Fill from empty with decode stalled.
        step(1'b1, 1'b1, 32'h0, 1'b0);
        check("flush_valid", {31'd0, id_valid_o}, 32'd0);
        check("flush_addr", imem_addr_o, 32'h0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("fill_count", 32'(u_dut.fifo_count), 32'd4);
        check("fill_addr", imem_addr_o, 32'd16);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("full_stall_addr", imem_addr_o, 32'd16);
        check("full_head_pc4", id_pc_plus4_o, 32'd4);

        // Full with pop: one in, one out each cycle.
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("fullpop_pc4", id_pc_plus4_o, 32'd8);
        check("fullpop_count", 32'(u_dut.fifo_count), 32'd4);
        check("fullpop_addr", imem_addr_o, 32'd20);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("fullpop2_pc4", id_pc_plus4_o, 32'd12);
        check("fullpop2_count", 32'(u_dut.fifo_count), 32'd4);

        // Redirect with three entries queued, unaligned target.
        step(1'b1, 1'b1, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b0);
        check("pre_redir_count", 32'(u_dut.fifo_count), 32'd3);
        step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
        check("redir_valid", {31'd0, id_valid_o}, 32'd0);
        check("redir_addr", imem_addr_o, 32'h0000_0100);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("redir_pc4", id_pc_plus4_o, 32'h0000_0104);
        check("redir_valid2", {31'd0, id_valid_o}, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        check("midrst_pre_count", 32'(u_dut.fifo_count), 32'd2);

        // Reset beats a simultaneous redirect.
        step(1'b0, 1'b1, 32'h0000_0500, 1'b0);
        check("midrst_addr", imem_addr_o, RESET_PC);
        check("midrst_valid", {31'd0, id_valid_o}, 32'd0);
`else
        // Bypass: empty queue forwards the memory word the same cycle.
        ovr_en  = 1'b1;
        ovr_val = 32'h2008_0005;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("byp_valid", {31'd0, id_valid_o}, 32'd1);
        check("byp_instr", id_instr_o, 32'h2008_0005);
        check("byp_pc4", id_pc_plus4_o, 32'd8);
        check("byp_count", 32'(u_dut.fifo_count), 32'd0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("byp_addr", imem_addr_o, 32'd8);
        check("byp_count2", 32'(u_dut.fifo_count), 32'd0);
        ovr_en = 1'b0;
`endif

        // Mixed ready pattern with redirects (incl. address wrap) and a reset.
        rdy_pat = 48'h5A3C_B3C5_0F96;
        for (int i = 0; i < 48; i++) begin
            if (i == 20)      step(1'b1, 1'b1, 32'h0000_2002, rdy_pat[i]);
            else if (i == 32) step(1'b1, 1'b1, 32'hFFFF_FFF6, rdy_pat[i]);
            else if (i == 42) step(1'b0, 1'b0, 32'h0, rdy_pat[i]);
            else              step(1'b1, 1'b0, 32'h0, rdy_pat[i]);
        end
        @(negedge clk_i);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
